// File: rtl/lbus_initiator_if.sv
// Core-side request/response and local-bus strobe signals of lbus_initiator.
// The initiator uses the master modport; the core/peripheral side uses slave.
interface lbus_initiator_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_write;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] lb_addr;
  logic [DATA_W-1:0] lb_wdata;
  logic              lb_we;
  logic              lb_re;
  logic [DATA_W-1:0] lb_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready, lb_rdata,
    output req_ready, resp_valid, resp_write, resp_rdata, resp_err,
           lb_addr, lb_wdata, lb_we, lb_re
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, resp_ready, lb_rdata,
    input  req_ready, resp_valid, resp_write, resp_rdata, resp_err,
           lb_addr, lb_wdata, lb_we, lb_re
  );
endinterface

// File: rtl/lbus_initiator.sv
// Local-bus initiator: queues core requests and issues one read/write strobe access per request.
// Optional feature LB_ADDR_CHECK_EN rejects misaligned or out-of-range addresses with resp_err.
module lbus_initiator #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 32,
  parameter int                FIFO_DEPTH  = 2,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [ADDR_W-1:0] MAX_ADDR    = 8'hFC
) (
  input logic              lb_clk,
  input logic              rst,
  lbus_initiator_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  logic              fifoWrite_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifoAddr_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifoWdata_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]  count_q;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              full, empty, push, pop;
  logic [ADDR_W-1:0] headAddr;
  logic              headBad;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = bus.req_valid && !full;
  assign headAddr = fifoAddr_q[rdPtr_q];

`ifdef LB_ADDR_CHECK_EN
  assign headBad = (headAddr[1:0] != 2'b00) || (headAddr > MAX_ADDR);
`else
  logic unusedMaxAddr;
  assign unusedMaxAddr = ^MAX_ADDR;
  assign headBad       = 1'b0;
`endif

  // Queue storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge lb_clk) begin
    if (push) begin
      fifoWrite_q[wrPtr_q] <= bus.req_write;
      fifoAddr_q[wrPtr_q]  <= bus.req_addr;
      fifoWdata_q[wrPtr_q] <= bus.req_wdata;
    end
  end

  always_ff @(posedge lb_clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge lb_clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) pop = 1'b1;
      end
      ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
          rdata_d = write_q ? '0 : bus.lb_rdata;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          if (!empty) pop = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop always loads the head entry; a rejected address bypasses the bus entirely.
    if (pop) begin
      addr_d  = headAddr;
      wdata_d = fifoWdata_q[rdPtr_q];
      write_d = fifoWrite_q[rdPtr_q];
      cnt_d   = 3'(WAIT_CYCLES);
      rdata_d = '0;
      err_d   = headBad;
      state_d = headBad ? RESP : ACCESS;
    end
  end

  assign bus.req_ready  = !full;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_write = write_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.lb_addr    = addr_q;
  assign bus.lb_wdata   = wdata_q;
  assign bus.lb_re      = (state_q == ACCESS) && !write_q;
  assign bus.lb_we      = (state_q == ACCESS) && write_q && (cnt_q == 3'd0);

endmodule

// File: tb/tb_lbus_initiator.sv
// Directed bench for lbus_initiator: one instance with WAIT_CYCLES=0 and one with WAIT_CYCLES=2,
// each with a simple peripheral model driving lb_rdata.
module tb_lbus_initiator;

  logic lbClk;
  logic rst;
  int   checkCount;
  int   errorCount;
  logic [31:0] reCntB;
  logic sawResp;

  lbus_initiator_if #(.ADDR_W(8), .DATA_W(32)) busA ();
  lbus_initiator_if #(.ADDR_W(8), .DATA_W(32)) busB ();

  lbus_initiator #(.WAIT_CYCLES(0)) dutA (
    .lb_clk (lbClk),
    .rst    (rst),
    .bus    (busA)
  );

  lbus_initiator #(.WAIT_CYCLES(2)) dutB (
    .lb_clk (lbClk),
    .rst    (rst),
    .bus    (busB)
  );

  initial lbClk = 1'b0;
  always #5 lbClk = ~lbClk;

  function automatic logic [31:0] slaveData(input logic [7:0] a);
    case (a)
      8'h08:   return 32'h0000_0155;
      8'h0C:   return 32'h0000_0ABC;
      8'hFC:   return 32'h0000_CAFE;
      default: return {24'h0, a};
    endcase
  endfunction

  assign busA.lb_rdata = busA.lb_re ? slaveData(busA.lb_addr) : 32'h0;

  // Peripheral B returns a value that changes every strobe cycle, exposing the capture point.
  always @(posedge lbClk) begin
    if (busB.lb_re !== 1'b1) reCntB <= 32'h0;
    else                     reCntB <= reCntB + 32'h1;
  end
  assign busB.lb_rdata = busB.lb_re ? (32'h0C00 + reCntB) : 32'h0;

  task automatic tick();
    @(posedge lbClk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] data);
    busA.req_valid = 1'b1;
    busA.req_write = wr;
    busA.req_addr  = addr;
    busA.req_wdata = data;
  endtask

  task automatic ackA();
    busA.resp_ready = 1'b1;
    tick();
    busA.resp_ready = 1'b0;
  endtask

  task automatic ackB();
    busB.resp_ready = 1'b1;
    tick();
    busB.resp_ready = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    busA.req_valid = 1'b0; busA.req_write = 1'b0; busA.req_addr = 8'h0;
    busA.req_wdata = 32'h0; busA.resp_ready = 1'b0;
    busB.req_valid = 1'b0; busB.req_write = 1'b0; busB.req_addr = 8'h0;
    busB.req_wdata = 32'h0; busB.resp_ready = 1'b0;
    tick(); tick(); tick();

    $display("[TB] reset state");
    checkOutput("rstReqReady", 32'(busA.req_ready), 32'd1);
    checkOutput("rstRespValid", 32'(busA.resp_valid), 32'd0);
    checkOutput("rstWe", 32'(busA.lb_we), 32'd0);
    checkOutput("rstRe", 32'(busA.lb_re), 32'd0);
    checkOutput("rstAddr", 32'(busA.lb_addr), 32'd0);
    checkOutput("rstErr", 32'(busA.resp_err), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] single write, no wait states");
    applyStimulus(1'b1, 8'h04, 32'h3FF);
    checkOutput("wrReady", 32'(busA.req_ready), 32'd1);
    tick(); busA.req_valid = 1'b0;
    checkOutput("wrT1We", 32'(busA.lb_we), 32'd0);
    tick();
    checkOutput("wrT2We", 32'(busA.lb_we), 32'd1);
    checkOutput("wrT2Addr", 32'(busA.lb_addr), 32'h04);
    checkOutput("wrT2Wdata", busA.lb_wdata, 32'h3FF);
    checkOutput("wrT2Resp", 32'(busA.resp_valid), 32'd0);
    tick();
    checkOutput("wrT3We", 32'(busA.lb_we), 32'd0);
    checkOutput("wrT3Resp", 32'(busA.resp_valid), 32'd1);
    checkOutput("wrT3RespWr", 32'(busA.resp_write), 32'd1);
    checkOutput("wrT3Rdata", busA.resp_rdata, 32'h0);
    ackA();
    checkOutput("wrAfterAck", 32'(busA.resp_valid), 32'd0);

    $display("[TB] single read");
    applyStimulus(1'b0, 8'h08, 32'h0);
    tick(); busA.req_valid = 1'b0;
    tick();
    checkOutput("rdT2Re", 32'(busA.lb_re), 32'd1);
    checkOutput("rdT2We", 32'(busA.lb_we), 32'd0);
    tick();
    checkOutput("rdT3Re", 32'(busA.lb_re), 32'd0);
    checkOutput("rdT3Resp", 32'(busA.resp_valid), 32'd1);
    checkOutput("rdT3Rdata", busA.resp_rdata, 32'h155);
    checkOutput("rdT3RespWr", 32'(busA.resp_write), 32'd0);
    ackA();

    $display("[TB] back-to-back with stalled responses");
    applyStimulus(1'b0, 8'h08, 32'h0);
    checkOutput("b2bReady0", 32'(busA.req_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 8'h10, 32'h77);
    checkOutput("b2bReady1", 32'(busA.req_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 8'h0C, 32'h0);
    checkOutput("b2bReady2", 32'(busA.req_ready), 32'd1);
    checkOutput("b2bRe0", 32'(busA.lb_re), 32'd1);
    tick(); busA.req_valid = 1'b0;
    checkOutput("b2bFull", 32'(busA.req_ready), 32'd0);
    checkOutput("b2bResp0", 32'(busA.resp_valid), 32'd1);
    checkOutput("b2bRdata0", busA.resp_rdata, 32'h155);
    busA.resp_ready = 1'b1;
    tick();
    checkOutput("b2bWe1", 32'(busA.lb_we), 32'd1);
    checkOutput("b2bAddr1", 32'(busA.lb_addr), 32'h10);
    checkOutput("b2bWdata1", busA.lb_wdata, 32'h77);
    checkOutput("b2bReadyAgain", 32'(busA.req_ready), 32'd1);
    tick();
    checkOutput("b2bResp1", 32'(busA.resp_valid), 32'd1);
    checkOutput("b2bRespWr1", 32'(busA.resp_write), 32'd1);
    tick();
    checkOutput("b2bRe2", 32'(busA.lb_re), 32'd1);
    checkOutput("b2bAddr2", 32'(busA.lb_addr), 32'h0C);
    tick();
    checkOutput("b2bResp2", 32'(busA.resp_valid), 32'd1);
    checkOutput("b2bRdata2", busA.resp_rdata, 32'hABC);
    tick();
    busA.resp_ready = 1'b0;
    checkOutput("b2bIdle", 32'(busA.resp_valid), 32'd0);

    $display("[TB] reset during read access");
    applyStimulus(1'b0, 8'h08, 32'h0);
    tick(); busA.req_valid = 1'b0;
    tick();
    checkOutput("rstMidRe", 32'(busA.lb_re), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstMidReLow", 32'(busA.lb_re), 32'd0);
    checkOutput("rstMidResp", 32'(busA.resp_valid), 32'd0);
    checkOutput("rstMidReady", 32'(busA.req_ready), 32'd1);
    sawResp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busA.resp_valid !== 1'b0 || busA.lb_re !== 1'b0) sawResp = 1'b1;
    end
    checkOutput("rstMidQuiet", 32'(sawResp), 32'd0);

    $display("[TB] address checking");
    applyStimulus(1'b0, 8'h06, 32'h0);
    tick(); busA.req_valid = 1'b0;
    tick();
`ifdef LB_ADDR_CHECK_EN
    checkOutput("badRe", 32'(busA.lb_re), 32'd0);
    checkOutput("badResp", 32'(busA.resp_valid), 32'd1);
    checkOutput("badErr", 32'(busA.resp_err), 32'd1);
    checkOutput("badRdata", busA.resp_rdata, 32'h0);
`else
    checkOutput("unchkRe", 32'(busA.lb_re), 32'd1);
    checkOutput("unchkAddr", 32'(busA.lb_addr), 32'h06);
    tick();
    checkOutput("unchkResp", 32'(busA.resp_valid), 32'd1);
    checkOutput("unchkErr", 32'(busA.resp_err), 32'd0);
    checkOutput("unchkRdata", busA.resp_rdata, 32'h06);
`endif
    ackA();
    applyStimulus(1'b0, 8'hFC, 32'h0);
    tick(); busA.req_valid = 1'b0;
    tick();
    checkOutput("topRe", 32'(busA.lb_re), 32'd1);
    tick();
    checkOutput("topResp", 32'(busA.resp_valid), 32'd1);
    checkOutput("topErr", 32'(busA.resp_err), 32'd0);
    checkOutput("topRdata", busA.resp_rdata, 32'hCAFE);
    ackA();

    $display("[TB] two wait states");
    busB.req_valid = 1'b1; busB.req_write = 1'b0; busB.req_addr = 8'h0C;
    tick(); busB.req_valid = 1'b0;
    checkOutput("wsRdT1", 32'(busB.lb_re), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("wsRdStrobe%0d", i), 32'(busB.lb_re), 32'd1);
      checkOutput($sformatf("wsRdAddr%0d", i), 32'(busB.lb_addr), 32'h0C);
    end
    tick();
    checkOutput("wsRdReLow", 32'(busB.lb_re), 32'd0);
    checkOutput("wsRdResp", 32'(busB.resp_valid), 32'd1);
    checkOutput("wsRdRdata", busB.resp_rdata, 32'h0C02);
    ackB();

    busB.req_valid = 1'b1; busB.req_write = 1'b1; busB.req_addr = 8'h20;
    busB.req_wdata = 32'h5A5;
    tick(); busB.req_valid = 1'b0;
    tick();
    checkOutput("wsWrWe0", 32'(busB.lb_we), 32'd0);
    checkOutput("wsWrAddr", 32'(busB.lb_addr), 32'h20);
    tick();
    checkOutput("wsWrWe1", 32'(busB.lb_we), 32'd0);
    tick();
    checkOutput("wsWrWe2", 32'(busB.lb_we), 32'd1);
    checkOutput("wsWrWdata", busB.lb_wdata, 32'h5A5);
    tick();
    checkOutput("wsWrWeLow", 32'(busB.lb_we), 32'd0);
    checkOutput("wsWrResp", 32'(busB.resp_valid), 32'd1);
    checkOutput("wsWrRespWr", 32'(busB.resp_write), 32'd1);
    ackB();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
